ddr_lane_serializer: RTL and testbench
======================================

DDR_LANE_SERIALIZER -- requirements
Module: ddr_lane_serializer

Interface
REQ-001 Parameter LANES, default 8: number of DDR data lanes.
REQ-002 Parameter WORD_W, default 32: parallel word width. Legal only if WORD_W = 2*LANES*BEATS with BEATS even and at least 2 (default BEATS = 2).
REQ-003 Parameter TRAIN_WORD, default 32'hA55A_F00F: word repeated in TRAIN state.
REQ-004 dco_clk  in  1  sole clock; all logic on posedge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 mode  in  2  mode select. 0 = OFF, 1 = TRAIN, 2 = DATA, 3 = OFF.
REQ-007 in_data  in  WORD_W  parallel word to transmit.
REQ-008 in_valid  in  1  in_data is valid.
REQ-009 in_ready  out  1  word accepted on an edge where in_valid and in_ready are both high.
REQ-010 rise  out  LANES  registered bits driven on the DCO high phase, for an external DDR output cell.
REQ-011 fall  out  LANES  registered bits driven on the DCO low phase.
REQ-012 frame  out  1  registered frame marker.
REQ-013 underrun  out  1  sticky underrun flag.
REQ-014 underrun_cnt  out  16  saturating underrun count.
REQ-015 underrun_clr  in  1  single-cycle clear of underrun and underrun_cnt.

Function
REQ-016 A free-running beat_cnt (0..BEATS-1) SHALL wrap from BEATS-1 to 0. A "boundary edge" is any posedge where beat_cnt = BEATS-1.
REQ-017 FSM states are OFF, TRAIN and DATA. State SHALL change only on a boundary edge, to the state selected by mode sampled at that edge.
REQ-018 mode changes between boundary edges SHALL have no effect until the next boundary edge.
REQ-019 The word emitted after a boundary edge is latched as follows:
- OFF: all zeros.
- TRAIN: TRAIN_WORD.
- DATA with in_valid=1: in_data.
- DATA with in_valid=0: all zeros, and an underrun event occurs.
REQ-020 in_ready SHALL be combinational: (beat_cnt = BEATS-1) AND (mode = 2). It SHALL be low on all other cycles and in OFF/TRAIN.
REQ-021 Beat b of the current word is chunk c = word[WORD_W-1-2*LANES*b -: 2*LANES]. rise SHALL equal c[2*LANES-1:LANES]; fall SHALL equal c[LANES-1:0]. Lane index equals bit index within each half.
REQ-022 Latency: a word accepted on edge k SHALL present beat 0 on rise/fall immediately after edge k, and beat b immediately after edge k+b.
REQ-023 The accepted word SHALL be held internally. A change on in_data after acceptance SHALL NOT alter the outputs.
REQ-024 frame SHALL be 1 while the beat shown on rise/fall is less than BEATS/2, and 0 otherwise, in all states including OFF.
REQ-025 Underrun event: set underrun and increment underrun_cnt, saturating at 16'hFFFF.
REQ-026 underrun_clr=1 SHALL clear underrun to 0 and underrun_cnt to 0.
REQ-027 If underrun_clr=1 and an underrun event occur on the same edge, the event wins: underrun=1, underrun_cnt=1.
REQ-028 Words back-to-back in DATA SHALL produce a continuous rise/fall stream with no idle beat.

Reset
REQ-029 While rst=1, the block SHALL hold:
- state = OFF
- beat_cnt = BEATS-1
- rise = 0, fall = 0, frame = 0
- underrun = 0, underrun_cnt = 0
REQ-030 in_ready SHALL be 1 during reset only if mode = 2.
REQ-031 The first posedge after rst deasserts SHALL be a boundary edge.
REQ-032 Asserting rst mid-word SHALL abort the word immediately. No partial beat SHALL be output after reset releases.

Verification
REQ-033 mode=2 with defaults; accept 32'h1234_5678 at edge k -> rise=8'h12, fall=8'h34, frame=1 after edge k; then rise=8'h56, fall=8'h78, frame=0 after edge k+1.
REQ-034 mode=1 for 3 words -> rise/fall sequence A5/5A, F0/0F repeated 3 times; in_ready=0 throughout.
REQ-035 mode=2, in_valid=0 at two boundary edges -> rise=fall=0 for 4 beats; underrun=1; underrun_cnt=2. Then pulse underrun_clr alone -> both cleared next edge.
REQ-036 mode switched 2->1 at a mid-word edge -> current DATA word completes both beats; TRAIN_WORD starts at the next boundary edge.
REQ-037 rst asserted after beat 0 of a DATA word -> outputs 0 asynchronously. After release, mode=2 with valid word 32'hDEAD_BEEF -> DE/AD then BE/EF, frame 1 then 0.
REQ-038 underrun_cnt at 16'hFFFF plus one more underrun -> stays 16'hFFFF. underrun_clr coincident with an underrun -> underrun_cnt=1.

Source files
------------

// File: rtl/ddr_lane_serializer.sv
// Parallel-word to DDR lane serializer: each word is sliced into BEATS beats of rise/fall
// lane pairs, with a training mode, frame marker and sticky/saturating underrun accounting.
module ddr_lane_serializer #(
    parameter int                LANES      = 8,
    parameter int                WORD_W     = 32,
    parameter logic [WORD_W-1:0] TRAIN_WORD = WORD_W'(32'hA55A_F00F)
) (
    input  logic              dco_clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANES-1:0]  rise,
    output logic [LANES-1:0]  fall,
    output logic              frame,
    output logic              underrun,
    output logic [15:0]       underrun_cnt,
    input  logic              underrun_clr
);

    localparam int CHUNK_W = 2 * LANES;
    localparam int BEATS   = WORD_W / CHUNK_W;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] HALF_BEAT = BEAT_W'(BEATS / 2);

    generate
        if ((WORD_W != CHUNK_W * BEATS) || (BEATS < 2) || ((BEATS % 2) != 0)) begin : g_bad_cfg
            $error("ddr_lane_serializer: WORD_W must equal 2*LANES*BEATS with BEATS even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StTrain = 2'd1,
        StData  = 2'd2
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_d;
    logic                boundary;
    logic [WORD_W-1:0]   word_q;
    logic [WORD_W-1:0]   word_d;
    logic [WORD_W-1:0]   shifted;
    logic [CHUNK_W-1:0]  chunk;
    logic [LANES-1:0]    rise_d;
    logic [LANES-1:0]    fall_d;
    logic                frame_d;
    logic                underrun_evt;
    logic                underrun_d;
    logic [15:0]         underrun_cnt_d;

    always_comb begin
        boundary = (beat_cnt == LAST_BEAT);
        in_ready = boundary && (mode == 2'd2);
    end

    // State register
    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            state_q <= StOff;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: mode is only honoured on a boundary edge
    always_comb begin
        state_d = state_q;
        if (boundary) begin
            case (mode)
                2'd1:    state_d = StTrain;
                2'd2:    state_d = StData;
                default: state_d = StOff;
            endcase
        end
    end

    // Output/datapath decode
    always_comb begin
        word_d       = word_q;
        underrun_evt = 1'b0;
        if (boundary) begin
            case (state_d)
                StTrain: word_d = TRAIN_WORD;
                StData: begin
                    if (in_valid) begin
                        word_d = in_data;
                    end else begin
                        word_d       = '0;
                        underrun_evt = 1'b1;
                    end
                end
                default: word_d = '0;
            endcase
        end

        beat_d  = boundary ? '0 : beat_cnt + BEAT_W'(1);
        // Beat 0 is the most significant chunk of the word
        shifted = word_d << (CHUNK_W * int'(beat_d));
        chunk   = shifted[WORD_W-1 -: CHUNK_W];
        rise_d  = chunk[CHUNK_W-1:LANES];
        fall_d  = chunk[LANES-1:0];
        frame_d = (beat_d < HALF_BEAT);
    end

    // An underrun on the same edge as a clear restarts the count at one
    always_comb begin
        underrun_d     = underrun;
        underrun_cnt_d = underrun_cnt;
        if (underrun_evt) begin
            underrun_d = 1'b1;
            if (underrun_clr) begin
                underrun_cnt_d = 16'd1;
            end else if (underrun_cnt != 16'hFFFF) begin
                underrun_cnt_d = underrun_cnt + 16'd1;
            end
        end else if (underrun_clr) begin
            underrun_d     = 1'b0;
            underrun_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            beat_cnt     <= LAST_BEAT;
            word_q       <= '0;
            rise         <= '0;
            fall         <= '0;
            frame        <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= 16'd0;
        end else begin
            beat_cnt     <= beat_d;
            word_q       <= word_d;
            rise         <= rise_d;
            fall         <= fall_d;
            frame        <= frame_d;
            underrun     <= underrun_d;
            underrun_cnt <= underrun_cnt_d;
        end
    end

endmodule

// File: tb/tb_ddr_lane_serializer.sv
// Scoreboard bench for ddr_lane_serializer: directed steps push hand-computed per-edge
// expectations; a monitor pops and compares one entry after each rising edge.
module tb_ddr_lane_serializer;

    logic        dco_clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        frame;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic        underrun_clr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  r;
        logic [7:0]  f;
        logic        fr;
        logic        ur;
        logic [15:0] cnt;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];

    ddr_lane_serializer dut (
        .dco_clk      (dco_clk),
        .rst          (rst),
        .mode         (mode),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rise         (rise),
        .fall         (fall),
        .frame        (frame),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .underrun_clr (underrun_clr)
    );

    always #5 dco_clk = ~dco_clk;

    // Drive inputs for the coming rising edge and queue what must be seen after it
    task automatic step(input logic [1:0] m, input logic v, input logic [31:0] d,
                        input logic c, input logic [7:0] er, input logic [7:0] ef,
                        input logic efr, input logic eu, input logic [15:0] ec,
                        input logic erdy);
        exp_t e;
        mode         = m;
        in_valid     = v;
        in_data      = d;
        underrun_clr = c;
        e.r   = er;
        e.f   = ef;
        e.fr  = efr;
        e.ur  = eu;
        e.cnt = ec;
        e.rdy = erdy;
        exp_q.push_back(e);
        @(negedge dco_clk);
    endtask

    // Monitor
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge dco_clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {rise, fall, frame, underrun, underrun_cnt, in_ready};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL edge_check t=%0t: got rise=%h fall=%h frame=%b ur=%b cnt=%h rdy=%b, want rise=%h fall=%h frame=%b ur=%b cnt=%h rdy=%b",
                             $time, got.r, got.f, got.fr, got.ur, got.cnt, got.rdy,
                             e.r, e.f, e.fr, e.ur, e.cnt, e.rdy);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        mode         = 2'd0;
        in_data      = '0;
        in_valid     = 1'b0;
        underrun_clr = 1'b0;
        @(negedge dco_clk);

        // Reset: everything zero; in_ready follows mode == DATA
        step(2'd0, 1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(2'd2, 1'b1, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1);
        rst = 1'b0;

        // DATA word, then in_data changes after acceptance; then back-to-back word
        step(2'd2, 1'b1, 32'h1234_5678, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(2'd2, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'h56, 8'h78, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(2'd2, 1'b1, 32'hAABB_CCDD, 1'b0, 8'hAA, 8'hBB, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(2'd2, 1'b0, 32'h0,         1'b0, 8'hCC, 8'hDD, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Two underruns
        step(2'd2, 1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h0001, 1'b0);
        step(2'd2, 1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0001, 1'b1);
        step(2'd2, 1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h0002, 1'b0);
        step(2'd2, 1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0002, 1'b1);

        // TRAIN words; clear pulsed alone mid-word
        step(2'd1, 1'b0, 32'h0, 1'b0, 8'hA5, 8'h5A, 1'b1, 1'b1, 16'h0002, 1'b0);
        step(2'd1, 1'b0, 32'h0, 1'b1, 8'hF0, 8'h0F, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(2'd1, 1'b0, 32'h0, 1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(2'd1, 1'b0, 32'h0, 1'b0, 8'hF0, 8'h0F, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(2'd1, 1'b1, 32'h0, 1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(2'd1, 1'b1, 32'h0, 1'b0, 8'hF0, 8'h0F, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Mode 2 -> 1 mid-word: DATA word completes, TRAIN follows at boundary
        step(2'd2, 1'b1, 32'h1122_3344, 1'b0, 8'h11, 8'h22, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(2'd1, 1'b1, 32'h0,         1'b0, 8'h33, 8'h44, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(2'd1, 1'b1, 32'h0,         1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(2'd1, 1'b1, 32'h0,         1'b0, 8'hF0, 8'h0F, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Reset after beat 0 of a DATA word aborts it asynchronously
        step(2'd2, 1'b1, 32'hCAFE_F00D, 1'b0, 8'hCA, 8'hFE, 1'b1, 1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({rise, fall, frame} !== 17'h0) begin
            errors++;
            $display("FAIL async_reset: got rise=%h fall=%h frame=%b, want 00 00 0",
                     rise, fall, frame);
        end
        @(negedge dco_clk);
        step(2'd2, 1'b1, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1);
        rst = 1'b0;
        step(2'd2, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'hDE, 8'hAD, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(2'd2, 1'b0, 32'h0,         1'b0, 8'hBE, 8'hEF, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Counter saturation, then clear coincident with an underrun
        step(2'd0, 1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0);
        force dut.underrun_cnt = 16'hFFFF;
        step(2'd0, 1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        release dut.underrun_cnt;
        step(2'd2, 1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        step(2'd2, 1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        step(2'd2, 1'b0, 32'h0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 16'h0001, 1'b0);
        step(2'd2, 1'b0, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0001, 1'b1);

        repeat (3) @(negedge dco_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
